// File: rtl/seg_capture.sv
// seg_capture: recovers the hex word shown on an 8-digit seven-segment
// display. It samples the segment buses every cycle, waits until the frame
// has been steady for STABLE_CYCLES edges, decodes each digit back to a
// nibble, and hands the word to a consumer over a valid/ready handshake.
module seg_capture #(
   parameter int unsigned STABLE_CYCLES = 4   // legal range 1..255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  seg0_i,
   input  logic [7:0]  seg1_i,
   input  logic [7:0]  seg2_i,
   input  logic [7:0]  seg3_i,
   input  logic [7:0]  seg4_i,
   input  logic [7:0]  seg5_i,
   input  logic [7:0]  seg6_i,
   input  logic [7:0]  seg7_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] data_o,
   output logic [7:0]  blank_o,
   output logic [7:0]  err_o,
   output logic        overrun_o
);

   localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

   // SETTLE: the sample is still proving itself; STABLE: the run is complete
   // and the frame has either been committed or suppressed as a duplicate.
   typedef enum logic {
      ST_SETTLE = 1'b0,
      ST_STABLE = 1'b1
   } state_t;

   // Result of decoding one digit.
   typedef struct packed {
      logic       err;
      logic       blank;
      logic [3:0] nib;
   } digit_t;

   // Maps the a..g pattern (dp already stripped) to a nibble plus flags.
   function automatic digit_t decode_glyph(input logic [6:0] pat);
      digit_t d;
      d = '{err: 1'b0, blank: 1'b0, nib: 4'h0};
      case (pat)
         7'h7E:   d.nib = 4'h0;
         7'h30:   d.nib = 4'h1;
         7'h6D:   d.nib = 4'h2;
         7'h79:   d.nib = 4'h3;
         7'h33:   d.nib = 4'h4;
         7'h5B:   d.nib = 4'h5;
         7'h5F:   d.nib = 4'h6;
         7'h70:   d.nib = 4'h7;
         7'h7F:   d.nib = 4'h8;
         7'h7B:   d.nib = 4'h9;
         7'h77:   d.nib = 4'hA;
         7'h1F:   d.nib = 4'hB;
         7'h4E:   d.nib = 4'hC;
         7'h3D:   d.nib = 4'hD;
         7'h4F:   d.nib = 4'hE;
         7'h47:   d.nib = 4'hF;
         7'h00:   d.blank = 1'b1;
         default: d.err = 1'b1;
      endcase
      return d;
   endfunction

   state_t      state_q, state_d;
   logic [63:0] s_q, s_d;
   logic [63:0] last_q, last_d;
   logic [7:0]  run_q, run_d;
   logic        has_commit_q, has_commit_d;
   logic        valid_q, valid_d;
   logic [31:0] data_q, data_d;
   logic [7:0]  blank_q, blank_d;
   logic [7:0]  err_q, err_d;
   logic        overrun_q, overrun_d;

   logic        changed;
   logic        run_done;
   logic        commit;
   logic [31:0] dec_data;
   logic [7:0]  dec_blank;
   logic [7:0]  dec_err;
   digit_t      dig;

   // Next sample and run-length counter; the counter saturates so it never wraps.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      s_d     = {seg7_i, seg6_i, seg5_i, seg4_i, seg3_i, seg2_i, seg1_i, seg0_i};
      changed = (s_d != s_q);
      run_d   = run_q;
      if (changed) begin
         run_d = 8'd1;
      end else if (run_q < RUN_MAX) begin
         run_d = run_q + 8'd1;
      end
   end

   // Decode the frame being sampled this edge; when it commits, s_d is the
   // value s_q is about to hold (identical to s_q unless STABLE_CYCLES is 1).
   always_comb begin
      dec_data  = '0;
      dec_blank = '0;
      dec_err   = '0;
      dig       = '0;
      for (int k = 0; k < 8; k++) begin
         dig                = decode_glyph(s_d[8*k+1 +: 7]);
         dec_data[4*k +: 4] = dig.nib;
         dec_blank[k]       = dig.blank;
         dec_err[k]         = dig.err;
      end
   end

   // Settle/stable FSM: flags the edge on which the run reaches STABLE_CYCLES
   // and suppresses the commit when the frame equals the last committed one.
   always_comb begin
      state_d  = state_q;
      run_done = 1'b0;
      case (state_q)
         ST_SETTLE: begin
            if (run_d == RUN_MAX) begin
               run_done = 1'b1;
               state_d  = ST_STABLE;
            end
         end
         ST_STABLE: begin
            if (changed) begin
               // A single-cycle run length completes on the change itself.
               if (run_d == RUN_MAX) begin
                  run_done = 1'b1;
               end else begin
                  state_d = ST_SETTLE;
               end
            end
         end
         default: state_d = ST_SETTLE;
      endcase
      commit = run_done && (!has_commit_q || (s_d != last_q));
   end

   // Output register and handshake: a commit always wins over an acceptance
   // on the same edge; a commit over an unaccepted frame flags an overrun.
   always_comb begin
      valid_d      = valid_q;
      data_d       = data_q;
      blank_d      = blank_q;
      err_d        = err_q;
      last_d       = last_q;
      has_commit_d = has_commit_q;
      overrun_d    = 1'b0;
      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
      if (commit) begin
         valid_d      = 1'b1;
         data_d       = dec_data;
         blank_d      = dec_blank;
         err_d        = dec_err;
         last_d       = s_d;
         has_commit_d = 1'b1;
         overrun_d    = valid_q && !ready_i;
      end
   end

   // State registers; reset discards all frame history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_SETTLE;
         s_q          <= '0;
         last_q       <= '0;
         run_q        <= '0;
         has_commit_q <= 1'b0;
         valid_q      <= 1'b0;
         data_q       <= '0;
         blank_q      <= '0;
         err_q        <= '0;
         overrun_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q      <= state_d;
         s_q          <= s_d;
         last_q       <= last_d;
         run_q        <= run_d;
         has_commit_q <= has_commit_d;
         valid_q      <= valid_d;
         data_q       <= data_d;
         blank_q      <= blank_d;
         err_q        <= err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign valid_o   = valid_q;
   assign data_o    = data_q;
   assign blank_o   = blank_q;
   assign err_o     = err_q;
   assign overrun_o = overrun_q;

endmodule

// File: tb/tb_seg_capture.sv
// Testbench for seg_capture: directed scenarios plus random frames, checked
// by a scoreboard fed from a frame-level reference model.
module tb_seg_capture;

   localparam int S = 4;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  blank;
      logic [7:0]  err;
   } frame_t;

   localparam logic [6:0] GLYPH [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   logic        clk;
   logic        rst_n;
   logic [63:0] seg_bus;
   logic        ready_i;
   logic        valid_o;
   logic [31:0] data_o;
   logic [7:0]  blank_o;
   logic [7:0]  err_o;
   logic        overrun_o;

   int total = 0;
   int bad   = 0;
   int n_acc = 0;

   // Reference model state: the previous sample, how many edges in a row it
   // has been seen, and the last frame that was handed out.
   logic [63:0] m_prev;
   int          m_len;
   logic        m_has;
   logic [63:0] m_last;
   logic        exp_overrun;
   frame_t      sb_q[$];

   seg_capture #(.STABLE_CYCLES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .seg0_i    (seg_bus[7:0]),
      .seg1_i    (seg_bus[15:8]),
      .seg2_i    (seg_bus[23:16]),
      .seg3_i    (seg_bus[31:24]),
      .seg4_i    (seg_bus[39:32]),
      .seg5_i    (seg_bus[47:40]),
      .seg6_i    (seg_bus[55:48]),
      .seg7_i    (seg_bus[63:56]),
      .ready_i   (ready_i),
      .valid_o   (valid_o),
      .data_o    (data_o),
      .blank_o   (blank_o),
      .err_o     (err_o),
      .overrun_o (overrun_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Shows a 32-bit value on the display, dp off.
   function automatic logic [63:0] enc(input logic [31:0] val);
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         r[8*k +: 8] = {GLYPH[val[4*k +: 4]], 1'b0};
      end
      return r;
   endfunction

   // Reads a display frame back by looking each digit up in the glyph table.
   function automatic frame_t read_frame(input logic [63:0] seg);
      frame_t f;
      logic [6:0] pat;
      logic found;
      f = '0;
      for (int k = 0; k < 8; k++) begin
         pat   = seg[8*k+1 +: 7];
         found = 1'b0;
         for (int g = 0; g < 16; g++) begin
            if (GLYPH[g] == pat) begin
               f.data[4*k +: 4] = 4'(g);
               found = 1'b1;
            end
         end
         if (!found) begin
            if (pat == 7'h00) f.blank[k] = 1'b1;
            else              f.err[k]   = 1'b1;
         end
      end
      return f;
   endfunction

   // Accounts for one active clock edge: the frame is handed out on the edge
   // where it has been seen for exactly S consecutive edges, unless it equals
   // the previous hand-out. An unaccepted frame still queued is replaced.
   task automatic model_edge();
      exp_overrun = 1'b0;
      if (seg_bus == m_prev) m_len++;
      else                   m_len = 1;
      m_prev = seg_bus;
      if (m_len == S && (!m_has || seg_bus != m_last)) begin
         if (sb_q.size() != 0) begin
            exp_overrun = 1'b1;
            void'(sb_q.pop_back());
         end
         sb_q.push_back(read_frame(seg_bus));
         m_has  = 1'b1;
         m_last = seg_bus;
      end
   endtask

   task automatic model_clear();
      m_prev      = '0;
      m_len       = 0;
      m_has       = 1'b0;
      m_last      = '0;
      exp_overrun = 1'b0;
      sb_q.delete();
   endtask

   // One clock: account for the edge just passed, then drive the next inputs.
   task automatic cycle(input logic [63:0] seg, input logic rdy);
      @(posedge clk);
      #1;
      model_edge();
      seg_bus = seg;
      ready_i = rdy;
   endtask

   task automatic hold(input logic [63:0] seg, input int n, input logic rdy);
      for (int i = 0; i < n; i++) cycle(seg, rdy);
   endtask

   // Asserts reset between edges, checks the cleared outputs, releases it.
   task automatic do_reset(input logic [63:0] seg, input int n);
      @(posedge clk);
      #1;
      if (rst_n) model_edge();
      rst_n   = 1'b0;
      seg_bus = seg;
      ready_i = 1'b1;
      model_clear();
      #1;
      check("rst_valid",   valid_o,   0);
      check("rst_data",    data_o,    0);
      check("rst_blank",   blank_o,   0);
      check("rst_err",     err_o,     0);
      check("rst_overrun", overrun_o, 0);
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: compares what the DUT presents against the scoreboard head and
   // retires the head whenever the consumer accepts it.
   initial begin
      forever begin
         @(negedge clk);
         check("valid",   valid_o,   sb_q.size() != 0);
         check("overrun", overrun_o, exp_overrun);
         if (sb_q.size() != 0) begin
            check("data",  data_o,  sb_q[0].data);
            check("blank", blank_o, sb_q[0].blank);
            check("err",   err_o,   sb_q[0].err);
            if (ready_i) begin
               void'(sb_q.pop_front());
               n_acc++;
            end
         end
      end
   end

   initial begin
      logic [63:0] f;
      logic [63:0] prev_f;
      rst_n   = 1'b0;
      seg_bus = '0;
      ready_i = 1'b0;
      model_clear();

      // Power-on reset; the first dark frame must still commit.
      do_reset(64'h0, 3);
      hold(64'h0, 6, 1'b1);

      // Plain frame, consumer ready.
      hold(enc(32'h12345678), 8, 1'b1);

      // Held frame with consumer stalled, then accepted; no recommit.
      hold(enc(32'hDEADBEEF), 24, 1'b0);
      hold(enc(32'hDEADBEEF), 6, 1'b1);

      // Short glitch on digit 3 of the committed frame.
      f = enc(32'hDEADBEEF);
      f[31:24] = 8'h80;
      hold(f, 2, 1'b1);
      hold(enc(32'hDEADBEEF), 8, 1'b1);

      // dp-only digit 5 is dark, digit 2 is illegal.
      f = enc(32'h0);
      f[47:40] = 8'h01;
      f[23:16] = 8'h94;
      hold(f, 6, 1'b1);

      // Overwrite of an unaccepted frame.
      hold(enc(32'h11111111), 6, 1'b0);
      hold(enc(32'h22222222), 6, 1'b0);
      hold(enc(32'h22222222), 3, 1'b1);

      // A -> short B -> A must not recommit A.
      hold(enc(32'hA5A5A5A5), 6, 1'b1);
      hold(enc(32'h5A5A5A5A), 2, 1'b1);
      hold(enc(32'hA5A5A5A5), 8, 1'b1);

      // Reset mid-settle after a dark frame; the dark frame commits again.
      hold(64'h0, 6, 1'b1);
      hold(enc(32'hCAFEF00D), 2, 1'b1);
      do_reset(64'h0, 2);
      hold(64'h0, 6, 1'b1);

      // Reset while an unaccepted frame is held.
      hold(enc(32'h13579BDF), 6, 1'b0);
      do_reset(64'h0, 2);
      hold(64'h0, 6, 1'b1);

      // Random frames: mostly glyphs, some dark, some garbage, random dp,
      // occasional repeats, random hold lengths and consumer stalls.
      prev_f = 64'h0;
      for (int it = 0; it < 150; it++) begin
         int n;
         if ($urandom_range(0, 5) == 0) begin
            f = prev_f;
         end else begin
            for (int k = 0; k < 8; k++) begin
               int r;
               r = int'($urandom_range(0, 19));
               if (r < 16)      f[8*k +: 8] = {GLYPH[r], 1'b0};
               else if (r < 18) f[8*k +: 8] = 8'h00;
               else             f[8*k +: 8] = 8'($urandom);
               if ($urandom_range(0, 7) == 0) f[8*k] = 1'b1;
            end
         end
         prev_f = f;
         n = int'($urandom_range(1, 7));
         for (int c = 0; c < n; c++) cycle(f, $urandom_range(0, 3) != 0);
      end

      // Drain.
      hold(prev_f, 4, 1'b1);
      check("accepted_frames", n_acc > 20, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
